// File: rtl/plb_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// plb_wr_arbiter_if
// Bundles the two framebuffer write clients and the PLB master IPIF write
// channel into one connection.
//   c0_* / c1_*  : client request, address, data, byte enables, plus the
//                  per-client grant / done / error strobes.
//   IP2Bus_*     : arbiter-driven IPIF command and data signals.
//   Bus2IP_*     : IPIF status returned to the arbiter.
// Modports:
//   master : the arbiter side (drives strobes and IP2Bus_*).
//   slave  : the environment side (drives client requests and Bus2IP_*).
// ---------------------------------------------------------------------------
interface plb_wr_arbiter_if #(
   parameter int C_MST_AWIDTH = 32,
   parameter int C_MST_DWIDTH = 32
);
   // client 0: rasterizer pixel writer
   logic                      c0_req;
   logic [C_MST_AWIDTH-1:0]   c0_addr;
   logic [C_MST_DWIDTH-1:0]   c0_data;
   logic [C_MST_DWIDTH/8-1:0] c0_be;
   logic                      c0_gnt;
   logic                      c0_done;
   logic                      c0_err;
   // client 1: clear/fill engine
   logic                      c1_req;
   logic [C_MST_AWIDTH-1:0]   c1_addr;
   logic [C_MST_DWIDTH-1:0]   c1_data;
   logic [C_MST_DWIDTH/8-1:0] c1_be;
   logic                      c1_gnt;
   logic                      c1_done;
   logic                      c1_err;
   // IPIF master write channel
   logic                      IP2Bus_MstRd_Req;
   logic                      IP2Bus_MstWr_Req;
   logic [C_MST_AWIDTH-1:0]   IP2Bus_Mst_Addr;
   logic [C_MST_DWIDTH/8-1:0] IP2Bus_Mst_BE;
   logic [C_MST_DWIDTH-1:0]   IP2Bus_MstWr_d;
   logic                      IP2Bus_Mst_Lock;
   logic                      IP2Bus_Mst_Reset;
   logic                      Bus2IP_Mst_CmdAck;
   logic                      Bus2IP_Mst_Cmplt;
   logic                      Bus2IP_Mst_Error;
   logic                      Bus2IP_Mst_Cmd_Timeout;

   modport master (
      input  c0_req, c0_addr, c0_data, c0_be,
      input  c1_req, c1_addr, c1_data, c1_be,
      output c0_gnt, c0_done, c0_err,
      output c1_gnt, c1_done, c1_err,
      output IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr,
      output IP2Bus_Mst_BE, IP2Bus_MstWr_d, IP2Bus_Mst_Lock, IP2Bus_Mst_Reset,
      input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
      input  Bus2IP_Mst_Cmd_Timeout
   );

   modport slave (
      output c0_req, c0_addr, c0_data, c0_be,
      output c1_req, c1_addr, c1_data, c1_be,
      input  c0_gnt, c0_done, c0_err,
      input  c1_gnt, c1_done, c1_err,
      input  IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr,
      input  IP2Bus_Mst_BE, IP2Bus_MstWr_d, IP2Bus_Mst_Lock, IP2Bus_Mst_Reset,
      output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
      output Bus2IP_Mst_Cmd_Timeout
   );
endinterface

// File: rtl/plb_wr_arbiter.sv
// ---------------------------------------------------------------------------
// plb_wr_arbiter
// Round-robin arbiter sharing the PLB master IPIF write channel between the
// rasterizer pixel writer (client 0) and the clear/fill engine (client 1).
// Each grant issues one single-beat write, tracked through command
// acknowledge and completion. Bus errors, command time-outs and a local
// acknowledge time-out abort the write and pulse IP2Bus_Mst_Reset.
// Ports:
//   PLB_clk : sole clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : plb_wr_arbiter_if master modport (client strobes + IPIF)
// Parameters:
//   C_MST_AWIDTH / C_MST_DWIDTH : IPIF address / data width
//   ACK_TIMEOUT : cycles allowed from issue to completion before abort
//   RST_CYCLES  : length of the IPIF master reset pulse (>= 1)
// ---------------------------------------------------------------------------
module plb_wr_arbiter #(
   parameter int C_MST_AWIDTH = 32,
   parameter int C_MST_DWIDTH = 32,
   parameter int ACK_TIMEOUT  = 255,
   parameter int RST_CYCLES   = 2
) (
   input  logic             PLB_clk,
   input  logic             reset_n,
   plb_wr_arbiter_if.master bus
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [TW-1:0] T_MAX  = TW'(ACK_TIMEOUT);
   localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CMPLT, RECOVER} state_t;

   state_t        state_reg;
   logic          owner_reg;   // client owning the write in flight
   logic          last_reg;    // most recent winner, loses the next tie
   logic [TW-1:0] tcnt_reg;    // cycles spent in ISSUE/WAIT_CMPLT
   logic [RW-1:0] rcnt_reg;    // cycles spent in RECOVER

   logic          any_req;
   logic          win;
   logic          bus_fault;
   logic          t_expired;
   logic [TW-1:0] tcnt_inc;

   assign any_req   = bus.c0_req | bus.c1_req;
   assign bus_fault = bus.Bus2IP_Mst_Error | bus.Bus2IP_Mst_Cmd_Timeout;
   assign t_expired = (tcnt_reg == T_MAX);
   assign tcnt_inc  = t_expired ? tcnt_reg : tcnt_reg + TW'(1);

   // On a tie the client that did not win last time takes the channel.
   always_comb begin
      win = bus.c1_req;
      if (bus.c0_req && bus.c1_req) begin
         win = ~last_reg;
      end
   end

   // Read channel and bus lock are never used by this master.
   assign bus.IP2Bus_MstRd_Req = 1'b0;
   assign bus.IP2Bus_Mst_Lock  = 1'b0;

   always_ff @(posedge PLB_clk) begin
      if (!reset_n) begin
         state_reg            <= IDLE;
         owner_reg            <= 1'b0;
         last_reg             <= 1'b1;
         tcnt_reg             <= '0;
         rcnt_reg             <= '0;
         bus.c0_gnt           <= 1'b0;
         bus.c1_gnt           <= 1'b0;
         bus.c0_done          <= 1'b0;
         bus.c1_done          <= 1'b0;
         bus.c0_err           <= 1'b0;
         bus.c1_err           <= 1'b0;
         bus.IP2Bus_MstWr_Req <= 1'b0;
         bus.IP2Bus_Mst_Addr  <= '0;
         bus.IP2Bus_Mst_BE    <= '0;
         bus.IP2Bus_MstWr_d   <= '0;
         bus.IP2Bus_Mst_Reset <= 1'b0;
      end else begin
         // strobes are single-cycle unless re-asserted below
         bus.c0_gnt  <= 1'b0;
         bus.c1_gnt  <= 1'b0;
         bus.c0_done <= 1'b0;
         bus.c1_done <= 1'b0;
         bus.c0_err  <= 1'b0;
         bus.c1_err  <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  if (win) begin
                     bus.IP2Bus_Mst_Addr <= bus.c1_addr;
                     bus.IP2Bus_MstWr_d  <= bus.c1_data;
                     bus.IP2Bus_Mst_BE   <= bus.c1_be;
                     bus.c1_gnt          <= 1'b1;
                  end else begin
                     bus.IP2Bus_Mst_Addr <= bus.c0_addr;
                     bus.IP2Bus_MstWr_d  <= bus.c0_data;
                     bus.IP2Bus_Mst_BE   <= bus.c0_be;
                     bus.c0_gnt          <= 1'b1;
                  end
                  owner_reg            <= win;
                  last_reg             <= win;
                  tcnt_reg             <= '0;
                  bus.IP2Bus_MstWr_Req <= 1'b1;
                  state_reg            <= ISSUE;
               end
            end

            ISSUE: begin
               tcnt_reg <= tcnt_inc;
               if (bus_fault) begin
                  bus.IP2Bus_MstWr_Req <= 1'b0;
                  bus.IP2Bus_Mst_Reset <= 1'b1;
                  bus.c0_err           <= ~owner_reg;
                  bus.c1_err           <= owner_reg;
                  rcnt_reg             <= '0;
                  state_reg            <= RECOVER;
               end else if (bus.Bus2IP_Mst_CmdAck && bus.Bus2IP_Mst_Cmplt) begin
                  bus.IP2Bus_MstWr_Req <= 1'b0;
                  bus.c0_done          <= ~owner_reg;
                  bus.c1_done          <= owner_reg;
                  state_reg            <= IDLE;
               end else if (bus.Bus2IP_Mst_CmdAck) begin
                  bus.IP2Bus_MstWr_Req <= 1'b0;
                  state_reg            <= WAIT_CMPLT;
               end else if (t_expired) begin
                  bus.IP2Bus_MstWr_Req <= 1'b0;
                  bus.IP2Bus_Mst_Reset <= 1'b1;
                  bus.c0_err           <= ~owner_reg;
                  bus.c1_err           <= owner_reg;
                  rcnt_reg             <= '0;
                  state_reg            <= RECOVER;
               end
            end

            WAIT_CMPLT: begin
               tcnt_reg <= tcnt_inc;
               if (bus_fault || (!bus.Bus2IP_Mst_Cmplt && t_expired)) begin
                  bus.IP2Bus_Mst_Reset <= 1'b1;
                  bus.c0_err           <= ~owner_reg;
                  bus.c1_err           <= owner_reg;
                  rcnt_reg             <= '0;
                  state_reg            <= RECOVER;
               end else if (bus.Bus2IP_Mst_Cmplt) begin
                  bus.c0_done <= ~owner_reg;
                  bus.c1_done <= owner_reg;
                  state_reg   <= IDLE;
               end
            end

            RECOVER: begin
               // Mst_Reset was raised on entry; hold it RST_CYCLES cycles.
               if (rcnt_reg == R_LAST) begin
                  bus.IP2Bus_Mst_Reset <= 1'b0;
                  state_reg            <= IDLE;
               end else begin
                  rcnt_reg <= rcnt_reg + RW'(1);
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_plb_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_plb_wr_arbiter
// Directed bench for plb_wr_arbiter (ACK_TIMEOUT = 8, RST_CYCLES = 2).
// A vector table covers contention, split acknowledge and bus errors; hand
// sequences cover the single write, the acknowledge time-out and reset in
// the middle of a transaction.
// ---------------------------------------------------------------------------
module tb_plb_wr_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [31:0] A0 = 32'h9000_0404;
   localparam logic [31:0] D0 = 32'h00FF_00FF;
   localparam logic [31:0] A1 = 32'hA000_0800;
   localparam logic [31:0] D1 = 32'h1234_5678;

   logic PLB_clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;

   plb_wr_arbiter_if #(.C_MST_AWIDTH(AW), .C_MST_DWIDTH(DW)) bus ();

   plb_wr_arbiter #(
      .C_MST_AWIDTH(AW),
      .C_MST_DWIDTH(DW),
      .ACK_TIMEOUT (8),
      .RST_CYCLES  (2)
   ) dut (
      .PLB_clk(PLB_clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial PLB_clk = 1'b0;
   always #5 PLB_clk = ~PLB_clk;

   // inputs per cycle, and the strobe vector expected in the following cycle:
   // {c0_gnt, c1_gnt, c0_done, c1_done, c0_err, c1_err, MstWr_Req, Mst_Reset}
   typedef struct {
      logic       r0;
      logic       r1;
      logic       ack;
      logic       cmp;
      logic       err;
      logic [7:0] exp;
   } vec_t;

   vec_t vq[$];

   function automatic logic [7:0] obs();
      return {bus.c0_gnt, bus.c1_gnt, bus.c0_done, bus.c1_done,
              bus.c0_err, bus.c1_err, bus.IP2Bus_MstWr_Req, bus.IP2Bus_Mst_Reset};
   endfunction

   task automatic step();
      @(posedge PLB_clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic add(input logic r0, input logic r1, input logic ack,
                      input logic cmp, input logic err, input logic [7:0] exp);
      vq.push_back('{r0, r1, ack, cmp, err, exp});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      int cnt;
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      bus.c0_req = 1'b0; bus.c0_addr = A0; bus.c0_data = D0; bus.c0_be = 4'hF;
      bus.c1_req = 1'b0; bus.c1_addr = A1; bus.c1_data = D1; bus.c1_be = 4'h3;
      bus.Bus2IP_Mst_CmdAck = 1'b0;
      bus.Bus2IP_Mst_Cmplt  = 1'b0;
      bus.Bus2IP_Mst_Error  = 1'b0;
      bus.Bus2IP_Mst_Cmd_Timeout = 1'b0;

      // contention from reset, then split ack, error with ack, error in WAIT
      add(1,1,0,0,0, 8'b1000_0010);
      add(1,1,1,1,0, 8'b0010_0000);
      add(1,1,0,0,0, 8'b0100_0010);
      add(1,1,1,1,0, 8'b0001_0000);
      add(1,1,0,0,0, 8'b1000_0010);
      add(1,1,1,1,0, 8'b0010_0000);
      add(1,1,0,0,0, 8'b0100_0010);
      add(0,0,1,1,0, 8'b0001_0000);
      add(0,0,0,0,0, 8'b0000_0000);
      add(1,0,0,0,0, 8'b1000_0010);
      add(0,0,1,0,0, 8'b0000_0000);
      add(0,0,0,0,0, 8'b0000_0000);
      add(0,0,0,0,0, 8'b0000_0000);
      add(0,0,0,0,0, 8'b0000_0000);
      add(0,0,0,0,0, 8'b0000_0000);
      add(0,0,0,1,0, 8'b0010_0000);
      add(0,0,0,0,0, 8'b0000_0000);
      add(0,1,0,0,0, 8'b0100_0010);
      add(0,0,1,1,1, 8'b0000_0101);
      add(0,0,0,0,0, 8'b0000_0001);
      add(0,0,0,0,0, 8'b0000_0000);
      add(0,0,0,0,0, 8'b0000_0000);
      add(0,1,0,0,0, 8'b0100_0010);
      add(0,0,1,0,0, 8'b0000_0000);
      add(1,0,0,0,0, 8'b0000_0000);
      add(1,0,0,0,1, 8'b0000_0101);
      add(1,0,0,0,0, 8'b0000_0001);
      add(1,0,0,0,0, 8'b0000_0000);
      add(1,0,0,0,0, 8'b1000_0010);
      add(0,0,1,1,0, 8'b0010_0000);
      add(0,0,0,0,0, 8'b0000_0000);

      // reset state
      step();
      step();
      chk("reset_strobes", 64'(obs()), 64'h0);
      chk("reset_addr", 64'(bus.IP2Bus_Mst_Addr), 64'h0);
      chk("tied_rd_lock", 64'({bus.IP2Bus_MstRd_Req, bus.IP2Bus_Mst_Lock}), 64'h0);

      // single write from client 0
      reset_n = 1'b1;
      bus.c0_req = 1'b1;
      step();
      chk("sw_gnt", 64'(obs()), 64'b1000_0010);
      chk("sw_addr", 64'(bus.IP2Bus_Mst_Addr), 64'(A0));
      chk("sw_data", 64'(bus.IP2Bus_MstWr_d), 64'(D0));
      chk("sw_be", 64'(bus.IP2Bus_Mst_BE), 64'hF);
      bus.c0_req = 1'b0;
      step();
      chk("sw_wr_req2", 64'(obs()), 64'b0000_0010);
      bus.Bus2IP_Mst_CmdAck = 1'b1;
      bus.Bus2IP_Mst_Cmplt  = 1'b1;
      step();
      chk("sw_done", 64'(obs()), 64'b0010_0000);
      bus.Bus2IP_Mst_CmdAck = 1'b0;
      bus.Bus2IP_Mst_Cmplt  = 1'b0;
      step();
      chk("sw_quiet", 64'(obs()), 64'h0);
      chk("sw_addr_hold", 64'(bus.IP2Bus_Mst_Addr), 64'(A0));

      // vector table, starting from a fresh reset so client 0 wins first
      do_reset();
      for (int i = 0; i < vq.size(); i++) begin
         bus.c0_req = vq[i].r0;
         bus.c1_req = vq[i].r1;
         bus.Bus2IP_Mst_CmdAck = vq[i].ack;
         bus.Bus2IP_Mst_Cmplt  = vq[i].cmp;
         bus.Bus2IP_Mst_Error  = vq[i].err;
         step();
         chk($sformatf("vec%0d", i), 64'(obs()), 64'(vq[i].exp));
         if (vq[i].exp[7]) chk($sformatf("vec%0d_addr0", i), 64'(bus.IP2Bus_Mst_Addr), 64'(A0));
         if (vq[i].exp[6]) chk($sformatf("vec%0d_addr1", i), 64'(bus.IP2Bus_Mst_Addr), 64'(A1));
      end
      bus.c0_req = 1'b0;
      bus.c1_req = 1'b0;
      bus.Bus2IP_Mst_CmdAck = 1'b0;
      bus.Bus2IP_Mst_Cmplt  = 1'b0;
      bus.Bus2IP_Mst_Error  = 1'b0;

      // acknowledge time-out: no response at all
      bus.c0_req = 1'b1;
      step();
      chk("to_gnt", 64'(obs()), 64'b1000_0010);
      bus.c0_req = 1'b0;
      cnt = 0;
      while (!bus.IP2Bus_Mst_Reset && cnt < 20) begin
         step();
         cnt++;
      end
      chk("to_cycles", 64'(cnt), 64'd9);
      chk("to_err", 64'(obs()), 64'b0000_1001);
      step();
      chk("to_rst2", 64'(obs()), 64'b0000_0001);
      step();
      chk("to_idle", 64'(obs()), 64'h0);

      // reset while in WAIT_CMPLT of a client 0 write
      bus.c0_req = 1'b1;
      step();
      chk("rm_gnt", 64'(obs()), 64'b1000_0010);
      bus.c0_req = 1'b0;
      bus.Bus2IP_Mst_CmdAck = 1'b1;
      step();
      bus.Bus2IP_Mst_CmdAck = 1'b0;
      chk("rm_wait", 64'(obs()), 64'h0);
      step();
      reset_n = 1'b0;
      step();
      chk("rm_strobes", 64'(obs()), 64'h0);
      chk("rm_addr", 64'(bus.IP2Bus_Mst_Addr), 64'h0);
      chk("rm_data_be", 64'({bus.IP2Bus_MstWr_d, bus.IP2Bus_Mst_BE}), 64'h0);
      reset_n = 1'b1;
      bus.Bus2IP_Mst_Cmplt = 1'b1;
      step();
      chk("rm_no_done", 64'(obs()), 64'h0);
      bus.Bus2IP_Mst_Cmplt = 1'b0;
      bus.c0_req = 1'b1;
      bus.c1_req = 1'b1;
      step();
      chk("rm_c0_wins", 64'(obs()), 64'b1000_0010);
      chk("rm_c0_addr", 64'(bus.IP2Bus_Mst_Addr), 64'(A0));
      bus.c0_req = 1'b0;
      bus.c1_req = 1'b0;
      bus.Bus2IP_Mst_CmdAck = 1'b1;
      bus.Bus2IP_Mst_Cmplt  = 1'b1;
      step();
      chk("rm_done", 64'(obs()), 64'b0010_0000);
      bus.Bus2IP_Mst_CmdAck = 1'b0;
      bus.Bus2IP_Mst_Cmplt  = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
